// File: rtl/t5_pkg.sv
// Shared definitions for the t5 decode stage: opcode classes, bubble word,
// immediate formats and small opcode-classification helpers.
package t5_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: imm_fmt = IMM_I;
            OPC_STORE:                                   imm_fmt = IMM_S;
            OPC_BRANCH:                                  imm_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:                          imm_fmt = IMM_U;
            OPC_JAL:                                     imm_fmt = IMM_J;
            default:                                     imm_fmt = IMM_Z;
        endcase
    endfunction

    function automatic logic opc_legal(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: opc_legal = 1'b1;
            default:                                            opc_legal = 1'b0;
        endcase
    endfunction

    function automatic logic opc_writes(input logic [4:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM,
            OPC_OP, OPC_SYSTEM: opc_writes = 1'b1;
            default:            opc_writes = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/t5_immgen.sv
// Combinational RV32I immediate generator; format selected from inst[6:2].
module t5_immgen
    import t5_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] dimm
);

    // Assemble and sign-extend the immediate for the instruction's format.
    always_comb begin
        dimm = 32'h0000_0000;
        case (imm_fmt(inst[6:2]))
            IMM_I:   dimm = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   dimm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   dimm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   dimm = {inst[31:12], 12'h000};
            IMM_J:   dimm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_Z:   dimm = 32'h0000_0000;
            default: dimm = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/t5_decode.sv
// Decode stage of the 4-hart barrel RV32I pipeline: early register-file read
// addresses plus a one-edge registered decoded bundle for execute.
module t5_decode
    import t5_pkg::*;
#(
    parameter int          XLEN = 32,
    parameter logic [31:0] NOP  = t5_pkg::NOP
) (
    input  logic            sclk,
    input  logic            srst,
    input  logic            sena,
    input  logic [XLEN-1:0] iwb_dat,
    input  logic            iwb_ack,
    input  logic [XLEN-1:0] fpc,
    input  logic [1:0]      fhart,
    output logic [6:0]      rra,
    output logic [6:0]      rrb,
    output logic [XLEN-1:0] dpc,
    output logic [1:0]      dhart,
    output logic [4:0]      dopc,
    output logic [2:0]      dfn3,
    output logic            dfn7,
    output logic [6:0]      drd,
    output logic [6:0]      drs1,
    output logic [6:0]      drs2,
    output logic [XLEN-1:0] dimm,
    output logic            dwre,
    output logic            dill,
    output logic            dvld
);

    logic [31:0] inst_s;
    logic [31:0] imm_s;
    logic        ill_s;
    logic        wre_s;

    // Read addresses come straight from the raw word; execute qualifies on dvld.
    assign rra = {fhart, iwb_dat[19:15]};
    assign rrb = {fhart, iwb_dat[24:20]};

    t5_immgen u_immgen (
        .inst (inst_s),
        .dimm (imm_s)
    );

    // Bubble substitution plus illegal and write-enable classification.
    always_comb begin
        inst_s = iwb_ack ? iwb_dat : NOP;
        ill_s  = 1'b0;
        wre_s  = 1'b0;
        if (iwb_ack) begin
            ill_s = (inst_s[1:0] != 2'b11) || !opc_legal(inst_s[6:2]) ||
                    ((inst_s[6:2] == OPC_JALR) && (inst_s[14:12] != 3'b000));
            wre_s = !ill_s && opc_writes(inst_s[6:2]) && (inst_s[11:7] != 5'd0);
        end else begin
            ill_s = 1'b0;
            wre_s = 1'b0;
        end
    end

    // Decoded bundle register; srst wins over sena, sena=0 holds everything.
    always_ff @(posedge sclk) begin
        if (srst) begin
            dpc   <= 32'h0000_0000;
            dhart <= 2'd0;
            dopc  <= 5'd0;
            dfn3  <= 3'd0;
            dfn7  <= 1'b0;
            drd   <= 7'd0;
            drs1  <= 7'd0;
            drs2  <= 7'd0;
            dimm  <= 32'h0000_0000;
            dwre  <= 1'b0;
            dill  <= 1'b0;
            dvld  <= 1'b0;
        end else if (sena) begin
            dpc   <= fpc;
            dhart <= fhart;
            dopc  <= inst_s[6:2];
            dfn3  <= inst_s[14:12];
            dfn7  <= inst_s[30];
            drd   <= {fhart, inst_s[11:7]};
            drs1  <= {fhart, inst_s[19:15]};
            drs2  <= {fhart, inst_s[24:20]};
            dimm  <= imm_s;
            dwre  <= wre_s;
            dill  <= ill_s;
            dvld  <= iwb_ack;
        end
    end

endmodule

// File: tb/tb_t5_decode.sv
// Scoreboard bench for t5_decode: directed vectors push hand-computed bundles,
// a monitor pops and compares one bundle after every clock edge.
module tb_t5_decode;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  hart;
        logic [4:0]  opc;
        logic [2:0]  fn3;
        logic        fn7;
        logic [6:0]  rd;
        logic [6:0]  rs1;
        logic [6:0]  rs2;
        logic [31:0] imm;
        logic        wre;
        logic        ill;
        logic        vld;
    } bundle_t;

    logic        sclk = 1'b0;
    logic        srst = 1'b1;
    logic        sena = 1'b1;
    logic [31:0] iwb_dat = 32'h0;
    logic        iwb_ack = 1'b0;
    logic [31:0] fpc = 32'h0;
    logic [1:0]  fhart = 2'd0;
    logic [6:0]  rra, rrb, drd, drs1, drs2;
    logic [31:0] dpc, dimm;
    logic [1:0]  dhart;
    logic [4:0]  dopc;
    logic [2:0]  dfn3;
    logic        dfn7, dwre, dill, dvld;

    bundle_t exp_q[$];
    bundle_t last_exp = '0;
    int checks = 0;
    int errors = 0;

    t5_decode dut (
        .sclk(sclk), .srst(srst), .sena(sena), .iwb_dat(iwb_dat), .iwb_ack(iwb_ack),
        .fpc(fpc), .fhart(fhart), .rra(rra), .rrb(rrb), .dpc(dpc), .dhart(dhart),
        .dopc(dopc), .dfn3(dfn3), .dfn7(dfn7), .drd(drd), .drs1(drs1), .drs2(drs2),
        .dimm(dimm), .dwre(dwre), .dill(dill), .dvld(dvld)
    );

    always #5 sclk = ~sclk;

    function automatic bundle_t mk(input logic [31:0] pc, input logic [1:0] hart,
                                   input logic [4:0] opc, input logic [2:0] fn3,
                                   input logic fn7, input logic [6:0] rd, rs1, rs2,
                                   input logic [31:0] imm, input logic wre, ill, vld);
        bundle_t b;
        b.pc = pc; b.hart = hart; b.opc = opc; b.fn3 = fn3; b.fn7 = fn7;
        b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
        b.wre = wre; b.ill = ill; b.vld = vld;
        return b;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue its expected bundle.
    task automatic drive(input logic en, rst, ack, input logic [31:0] dat, pc,
                         input logic [1:0] hart, input bundle_t exp_b,
                         input logic [6:0] e_rra, e_rrb, input string name);
        bundle_t e;
        @(negedge sclk);
        sena = en; srst = rst; iwb_ack = ack; iwb_dat = dat; fpc = pc; fhart = hart;
        if (rst) e = '0;
        else if (!en) e = last_exp;
        else e = exp_b;
        last_exp = e;
        exp_q.push_back(e);
        #1;
        checks++;
        if (rra !== e_rra || rrb !== e_rrb) begin
            errors++;
            $display("FAIL %s rra/rrb: got %h/%h expected %h/%h", name, rra, rrb, e_rra, e_rrb);
        end
    endtask

    // Monitor: one bundle per edge, compared against the scoreboard head.
    initial begin
        bundle_t act, e;
        forever begin
            @(posedge sclk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                act = mk(dpc, dhart, dopc, dfn3, dfn7, drd, drs1, drs2, dimm, dwre, dill, dvld);
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL bundle: got pc=%h h=%0d opc=%h f3=%0d f7=%b rd=%h rs1=%h rs2=%h imm=%h wre=%b ill=%b vld=%b expected pc=%h h=%0d opc=%h f3=%0d f7=%b rd=%h rs1=%h rs2=%h imm=%h wre=%b ill=%b vld=%b",
                             act.pc, act.hart, act.opc, act.fn3, act.fn7, act.rd, act.rs1, act.rs2, act.imm, act.wre, act.ill, act.vld,
                             e.pc, e.hart, e.opc, e.fn3, e.fn7, e.rd, e.rs1, e.rs2, e.imm, e.wre, e.ill, e.vld);
                end
            end
        end
    end

    initial begin
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 2'd0, '0, 7'h00, 7'h00, "reset0");
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 2'd0, '0, 7'h00, 7'h00, "reset1");
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0,
              mk(32'h0, 2'd0, 5'h04, 3'd0, 1'b0, 7'h00, 7'h00, 7'h00, 32'h0, 1'b0, 1'b0, 1'b0), 7'h00, 7'h00, "release");
        drive(1'b1, 1'b0, 1'b1, 32'h00A30293, 32'h102, 2'd2,
              mk(32'h102, 2'd2, 5'h04, 3'd0, 1'b0, 7'h45, 7'h46, 7'h4A, 32'h0000000A, 1'b1, 1'b0, 1'b1), 7'h46, 7'h4A, "addi");
        drive(1'b1, 1'b0, 1'b1, 32'hFE000EE3, 32'h200, 2'd0,
              mk(32'h200, 2'd0, 5'h18, 3'd0, 1'b1, 7'h1D, 7'h00, 7'h00, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b1), 7'h00, 7'h00, "beq");
        drive(1'b1, 1'b0, 1'b1, 32'h12345037, 32'h301, 2'd1,
              mk(32'h301, 2'd1, 5'h0D, 3'd5, 1'b0, 7'h20, 7'h28, 7'h23, 32'h12345000, 1'b0, 1'b0, 1'b1), 7'h28, 7'h23, "lui");
        drive(1'b1, 1'b0, 1'b1, 32'h800000EF, 32'h403, 2'd3,
              mk(32'h403, 2'd3, 5'h1B, 3'd0, 1'b0, 7'h61, 7'h60, 7'h60, 32'hFFF00000, 1'b1, 1'b0, 1'b1), 7'h60, 7'h60, "jal");
        drive(1'b1, 1'b0, 1'b1, 32'h00000000, 32'h500, 2'd0,
              mk(32'h500, 2'd0, 5'h00, 3'd0, 1'b0, 7'h00, 7'h00, 7'h00, 32'h0, 1'b0, 1'b1, 1'b1), 7'h00, 7'h00, "zero_ill");
        drive(1'b1, 1'b0, 1'b0, 32'h0000707F, 32'h601, 2'd1,
              mk(32'h601, 2'd1, 5'h04, 3'd0, 1'b0, 7'h20, 7'h20, 7'h20, 32'h0, 1'b0, 1'b0, 1'b0), 7'h20, 7'h20, "bubble");
        drive(1'b1, 1'b0, 1'b1, 32'h00001067, 32'h800, 2'd0,
              mk(32'h800, 2'd0, 5'h19, 3'd1, 1'b0, 7'h00, 7'h00, 7'h00, 32'h0, 1'b0, 1'b1, 1'b1), 7'h00, 7'h00, "jalr_f3");
        drive(1'b1, 1'b0, 1'b1, 32'h000080E7, 32'h801, 2'd1,
              mk(32'h801, 2'd1, 5'h19, 3'd0, 1'b0, 7'h21, 7'h21, 7'h20, 32'h0, 1'b1, 1'b0, 1'b1), 7'h21, 7'h20, "jalr");
        drive(1'b1, 1'b0, 1'b1, 32'h00A30290, 32'h900, 2'd0,
              mk(32'h900, 2'd0, 5'h04, 3'd0, 1'b0, 7'h05, 7'h06, 7'h0A, 32'h0000000A, 1'b0, 1'b1, 1'b1), 7'h06, 7'h0A, "low_bits");
        // Stage disabled: outputs must hold the low_bits bundle.
        drive(1'b0, 1'b0, 1'b1, 32'h12345037, 32'hA01, 2'd1, '0, 7'h28, 7'h23, "hold0");
        drive(1'b0, 1'b0, 1'b0, 32'h800000EF, 32'hA03, 2'd3, '0, 7'h60, 7'h60, "hold1");
        drive(1'b0, 1'b0, 1'b1, 32'h00A30293, 32'hA02, 2'd2, '0, 7'h46, 7'h4A, "hold2");
        drive(1'b1, 1'b0, 1'b1, 32'h00A30293, 32'hA00, 2'd0,
              mk(32'hA00, 2'd0, 5'h04, 3'd0, 1'b0, 7'h05, 7'h06, 7'h0A, 32'h0000000A, 1'b1, 1'b0, 1'b1), 7'h06, 7'h0A, "resume");
        drive(1'b1, 1'b1, 1'b1, 32'h00A30293, 32'hB02, 2'd2, '0, 7'h46, 7'h4A, "mid_reset");
        drive(1'b1, 1'b0, 1'b1, 32'h800000EF, 32'h403, 2'd3,
              mk(32'h403, 2'd3, 5'h1B, 3'd0, 1'b0, 7'h61, 7'h60, 7'h60, 32'hFFF00000, 1'b1, 1'b0, 1'b1), 7'h60, 7'h60, "jal2");
        drive(1'b0, 1'b1, 1'b1, 32'h800000EF, 32'h403, 2'd3, '0, 7'h60, 7'h60, "reset_over_ena");
        // Hart sweep 0,1,3,2 with the same instruction.
        drive(1'b1, 1'b0, 1'b1, 32'h00A30293, 32'h700, 2'd0,
              mk(32'h700, 2'd0, 5'h04, 3'd0, 1'b0, 7'h05, 7'h06, 7'h0A, 32'h0000000A, 1'b1, 1'b0, 1'b1), 7'h06, 7'h0A, "hart0");
        drive(1'b1, 1'b0, 1'b1, 32'h00A30293, 32'h701, 2'd1,
              mk(32'h701, 2'd1, 5'h04, 3'd0, 1'b0, 7'h25, 7'h26, 7'h2A, 32'h0000000A, 1'b1, 1'b0, 1'b1), 7'h26, 7'h2A, "hart1");
        drive(1'b1, 1'b0, 1'b1, 32'h00A30293, 32'h703, 2'd3,
              mk(32'h703, 2'd3, 5'h04, 3'd0, 1'b0, 7'h65, 7'h66, 7'h6A, 32'h0000000A, 1'b1, 1'b0, 1'b1), 7'h66, 7'h6A, "hart3");
        drive(1'b1, 1'b0, 1'b1, 32'h00A30293, 32'h702, 2'd2,
              mk(32'h702, 2'd2, 5'h04, 3'd0, 1'b0, 7'h45, 7'h46, 7'h4A, 32'h0000000A, 1'b1, 1'b0, 1'b1), 7'h46, 7'h4A, "hart2");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge sclk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d bundles still pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
